// File: rtl/ts_pkg.sv
// Task-scheduler shared definitions: fence encodings, FSM state enum and
// control-frame (CF) field offsets. The CF layout, LSB first, is:
//   IF_NUM[7:0] | FENCE[1:0] | ACTIVE[N] | R0_VECT[N] | R0[N*REG_W] | STOP | STOP_ADDR[log2 depth]
package ts_pkg;

  typedef enum logic [1:0] {
    FENCE_NO   = 2'd0,
    FENCE_ACQ  = 2'd1,
    FENCE_REL  = 2'd2,
    FENCE_RSVD = 2'd3
  } fence_e;

  typedef enum logic [1:0] {
    FETCH_CF = 2'd0,
    WAIT_IF  = 2'd1,
    LOAD     = 2'd2,
    PARK     = 2'd3
  } state_e;

  localparam int IFN_W   = 8;
  localparam int FENCE_W = 2;

  function automatic int off_if_num();
    return 0;
  endfunction

  function automatic int off_fence();
    return IFN_W;
  endfunction

  function automatic int off_active();
    return IFN_W + FENCE_W;
  endfunction

  function automatic int off_r0_vect(input int n);
    return off_active() + n;
  endfunction

  function automatic int off_r0(input int n);
    return off_active() + 2 * n;
  endfunction

  function automatic int off_stop(input int n, input int rw);
    return off_r0(n) + n * rw;
  endfunction

  function automatic int off_stop_addr(input int n, input int rw);
    return off_stop(n, rw) + 1;
  endfunction

endpackage

// File: rtl/ts_frame_decode.sv
// Combinational extraction of control-frame fields from one task-memory frame.
module ts_frame_decode
  import ts_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int REG_W     = 8,
  parameter int FRAME_W   = 64,
  parameter int AW        = 4
) (
  input  logic [FRAME_W-1:0]         frame_i,
  output logic [IFN_W-1:0]           if_num_o,
  output fence_e                     fence_o,
  output logic [NUM_CORES-1:0]       active_o,
  output logic [NUM_CORES-1:0]       r0_vect_o,
  output logic [NUM_CORES*REG_W-1:0] r0_o,
  output logic                       stop_o,
  output logic [AW-1:0]              stop_addr_o
);

  localparam int OFF_IFN   = off_if_num();
  localparam int OFF_FENCE = off_fence();
  localparam int OFF_ACT   = off_active();
  localparam int OFF_R0V   = off_r0_vect(NUM_CORES);
  localparam int OFF_R0    = off_r0(NUM_CORES);
  localparam int OFF_STOP  = off_stop(NUM_CORES, REG_W);
  localparam int OFF_SADDR = off_stop_addr(NUM_CORES, REG_W);
  localparam int CF_W      = OFF_SADDR + AW;

  assign if_num_o    = frame_i[OFF_IFN +: IFN_W];
  assign fence_o     = fence_e'(frame_i[OFF_FENCE +: FENCE_W]);
  assign active_o    = frame_i[OFF_ACT +: NUM_CORES];
  assign r0_vect_o   = frame_i[OFF_R0V +: NUM_CORES];
  assign r0_o        = frame_i[OFF_R0 +: NUM_CORES*REG_W];
  assign stop_o      = frame_i[OFF_STOP];
  assign stop_addr_o = frame_i[OFF_SADDR +: AW];

  // Bits above the CF fields are don't-care in a control frame.
  if (CF_W < FRAME_W) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^frame_i[FRAME_W-1:CF_W];
  end

endmodule

// File: rtl/param_task_scheduler.sv
// Task scheduler: walks a flat task memory, accepts control frames when the
// addressed cores are idle, and streams instruction frames to them beat by beat.
// Optional build macro TS_VGA_SYNC_EN adds a frame-tick generator and makes the
// parked state wait for a vga_end rising edge.
module param_task_scheduler
  import ts_pkg::*;
#(
  parameter int NUM_CORES   = 4,
  parameter int TM_DEPTH    = 16,
  parameter int LOAD_TIME   = 4,
  parameter int INSN_W      = 16,
  parameter int REG_W       = 8,
`ifdef TS_VGA_SYNC_EN
  parameter int FRAME_TICKS = 833333,
`endif
  localparam int FRAME_W    = LOAD_TIME * INSN_W,
  localparam int CNT_W      = (LOAD_TIME > 1) ? $clog2(LOAD_TIME) : 1,
  localparam int AW         = $clog2(TM_DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [TM_DEPTH*FRAME_W-1:0]   env_task_memory,
  input  logic [NUM_CORES-1:0]          Ready,
`ifdef TS_VGA_SYNC_EN
  input  logic                          vga_end,
  output logic                          vga_en,
`endif
  output logic [NUM_CORES-1:0]          Start,
  output logic [CNT_W-1:0]              Insn_Load_Counter,
  output logic [INSN_W-1:0]             Insn_Data,
  output logic [NUM_CORES-1:0]          Init_R0_Vect,
  output logic [NUM_CORES*REG_W-1:0]    Init_R0,
  output logic                          halted,
  output logic [15:0]                   frames_issued
);

  state_e                     state_q;
  fence_e                     fence_q;
  logic [AW-1:0]              tp_q;
  logic [IFN_W-1:0]           frames_left_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [15:0]                issued_q;
  logic [NUM_CORES-1:0]       start_q;
  logic [NUM_CORES-1:0]       active_q;
  logic [NUM_CORES-1:0]       r0_vect_q;
  logic [NUM_CORES*REG_W-1:0] r0_q;
  logic                       stop_q;
  logic [AW-1:0]              stop_addr_q;
  logic                       halted_q;

  logic [FRAME_W-1:0] tm [TM_DEPTH];
  logic [INSN_W-1:0]  beat [LOAD_TIME];
  logic [FRAME_W-1:0] cur_frame;

  for (genvar i = 0; i < TM_DEPTH; i++) begin : g_tm
    assign tm[i] = env_task_memory[i*FRAME_W +: FRAME_W];
  end

  assign cur_frame = tm[tp_q];

  for (genvar b = 0; b < LOAD_TIME; b++) begin : g_beat
    assign beat[b] = cur_frame[b*INSN_W +: INSN_W];
  end

  logic [IFN_W-1:0]           cf_if_num;
  fence_e                     cf_fence;
  logic [NUM_CORES-1:0]       cf_active;
  logic [NUM_CORES-1:0]       cf_r0_vect;
  logic [NUM_CORES*REG_W-1:0] cf_r0;
  logic                       cf_stop;
  logic [AW-1:0]              cf_stop_addr;

  ts_frame_decode #(
    .NUM_CORES (NUM_CORES),
    .REG_W     (REG_W),
    .FRAME_W   (FRAME_W),
    .AW        (AW)
  ) u_decode (
    .frame_i     (cur_frame),
    .if_num_o    (cf_if_num),
    .fence_o     (cf_fence),
    .active_o    (cf_active),
    .r0_vect_o   (cf_r0_vect),
    .r0_o        (cf_r0),
    .stop_o      (cf_stop),
    .stop_addr_o (cf_stop_addr)
  );

  logic all_ready;
  logic need_all;
  logic accept;
  logic park_exit;

  assign all_ready = &Ready;
  // An acquire fence left by a stop frame, or a release request in the new CF,
  // forces a full barrier across every core before the CF is taken.
  assign need_all  = (fence_q == FENCE_ACQ) || (cf_fence == FENCE_REL);
  assign accept    = need_all ? all_ready : ((Ready & cf_active) == cf_active);

`ifdef TS_VGA_SYNC_EN
  localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  logic [TW-1:0] tick_q;
  logic          vga_end_q;
  logic          vga_en_q;

  // Free-running frame tick counter, vga_en strobe and vga_end edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q    <= '0;
      vga_end_q <= 1'b0;
      vga_en_q  <= 1'b0;
    end else begin
      tick_q    <= (tick_q == TW'(FRAME_TICKS - 1)) ? '0 : tick_q + 1'b1;
      vga_end_q <= vga_end;
      vga_en_q  <= (tick_q == TW'(FRAME_TICKS - 1)) && all_ready;
    end
  end

  assign vga_en    = vga_en_q;
  assign park_exit = vga_end & ~vga_end_q;
`else
  assign park_exit = all_ready;
`endif

  // Scheduler FSM with its pointer, frame and beat counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH_CF;
      fence_q       <= FENCE_NO;
      tp_q          <= '0;
      frames_left_q <= '0;
      cnt_q         <= '0;
      issued_q      <= '0;
      start_q       <= '0;
      active_q      <= '0;
      r0_vect_q     <= '0;
      r0_q          <= '0;
      stop_q        <= 1'b0;
      stop_addr_q   <= '0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        FETCH_CF: begin
          if (accept) begin
            active_q      <= cf_active;
            fence_q       <= cf_fence;
            stop_q        <= cf_stop;
            stop_addr_q   <= cf_stop_addr;
            frames_left_q <= cf_if_num;
            r0_vect_q     <= cf_r0_vect;
            r0_q          <= cf_r0;
            if ((cf_if_num == '0) && cf_stop) begin
              tp_q     <= cf_stop_addr;
              halted_q <= 1'b1;
              state_q  <= PARK;
            end else begin
              tp_q <= tp_q + 1'b1;
              if (cf_if_num != '0) state_q <= WAIT_IF;
            end
          end
        end
        WAIT_IF: begin
          if ((Ready & active_q) == active_q) begin
            start_q <= active_q;
            cnt_q   <= '0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          // Once started, a burst always runs to its last beat regardless of Ready.
          if (cnt_q == CNT_W'(LOAD_TIME - 1)) begin
            start_q       <= '0;
            cnt_q         <= '0;
            frames_left_q <= frames_left_q - 1'b1;
            issued_q      <= issued_q + 16'd1;
            if (frames_left_q == IFN_W'(1)) begin
              tp_q    <= stop_q ? stop_addr_q : tp_q + 1'b1;
              if (stop_q) fence_q <= FENCE_ACQ;
              state_q <= FETCH_CF;
            end else begin
              tp_q    <= tp_q + 1'b1;
              state_q <= WAIT_IF;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PARK: begin
          if (park_exit) begin
            halted_q <= 1'b0;
            state_q  <= FETCH_CF;
          end
        end
        default: state_q <= FETCH_CF;
      endcase
    end
  end

  assign Start             = start_q;
  assign Insn_Load_Counter = cnt_q;
  assign Insn_Data         = (state_q == LOAD) ? beat[cnt_q] : '0;
  assign Init_R0_Vect      = r0_vect_q;
  assign Init_R0           = r0_q;
  assign halted            = halted_q;
  assign frames_issued     = issued_q;

endmodule

// File: doc/param_task_scheduler.md
PARAM_TASK_SCHEDULER -- requirements
Module: param_task_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of cores served.
REQ-002 SHALL have parameter TM_DEPTH, default 16, task-memory frames; a power of two, at least 2.
REQ-003 SHALL have parameter LOAD_TIME, default 4, bus beats per instruction frame.
REQ-004 SHALL have parameter INSN_W, default 16, instruction bus width per beat.
REQ-005 SHALL have parameter REG_W, default 8, R0 init width per core.
REQ-006 SHALL have port clk, input, 1, sole clock.
REQ-007 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-008 SHALL have port env_task_memory, input, TM_DEPTH*FRAME_W, flat task memory; frame i occupies bits [i*FRAME_W +: FRAME_W].
REQ-009 SHALL have port Ready, input, NUM_CORES, per-core idle flags.
REQ-010 SHALL have port Start, output, NUM_CORES, per-core load/start strobe.
REQ-011 SHALL have port Insn_Load_Counter, output, clog2(LOAD_TIME), current beat index.
REQ-012 SHALL have port Insn_Data, output, INSN_W, current beat payload.
REQ-013 SHALL have port Init_R0_Vect, output, NUM_CORES, cores whose R0 is preset.
REQ-014 SHALL have port Init_R0, output, NUM_CORES*REG_W, R0 values.
REQ-015 SHALL have port halted, output, 1, set while parked after a stop frame.
REQ-016 SHALL have port frames_issued, output, 16, wrapping count of completed instruction frames.

Function
REQ-017 Frame width FRAME_W = LOAD_TIME*INSN_W. A control frame (CF) holds these fields: IF_NUM, FENCE, ACTIVE, R0_VECT, R0[NUM_CORES], STOP, STOP_ADDR.
REQ-018 FENCE encoding: NO=0, ACQ=1, REL=2, 3=reserved (treated as NO).
REQ-019 The FSM SHALL have states FETCH_CF, WAIT_IF, LOAD, and PARK, and SHALL leave reset in FETCH_CF.
REQ-020 FETCH_CF, acceptance rule:
- If the latched fence is ACQ, or the new CF's FENCE is REL, accept only when all Ready=1.
- Otherwise accept when the Ready of every core in the new ACTIVE is 1.
REQ-021 On acceptance, in one cycle:
- Latch ACTIVE, FENCE, STOP, STOP_ADDR.
- Load frames_left=IF_NUM.
- Update Init_R0_Vect and Init_R0.
- Task_Pointer+1, mod TM_DEPTH.
REQ-022 Next state after acceptance:
- IF_NUM=0 with STOP=1: Task_Pointer<=STOP_ADDR, go to PARK.
- IF_NUM=0 with STOP=0: stay in FETCH_CF.
- Otherwise: go to WAIT_IF.
REQ-023 WAIT_IF SHALL move to LOAD when Ready&ACTIVE == ACTIVE, meaning the previous frame has finished.
REQ-024 LOAD SHALL drive Start=ACTIVE for exactly LOAD_TIME consecutive cycles, with Insn_Load_Counter=0..LOAD_TIME-1 and Insn_Data=frame beat [cnt]. Start SHALL be 0 in every other state.
REQ-025 On the last beat:
- frames_left-1 and frames_issued+1.
- If frames_left was 1: Task_Pointer<=STOP?STOP_ADDR:TP+1; if STOP was set, the latched fence becomes ACQ; next state is FETCH_CF.
- Otherwise: TP+1 and next state is WAIT_IF.
REQ-026 Ready deasserting mid-LOAD SHALL NOT abort the burst.
REQ-027 Task_Pointer SHALL wrap from TM_DEPTH-1 to 0.
REQ-028 In PARK, halted=1; the block SHALL resume in FETCH_CF at Task_Pointer when all Ready=1 (plus the sync condition if TS_VGA_SYNC_EN is defined).

Reset
REQ-029 Asserting reset SHALL immediately (asynchronously) set the following, aborting any LOAD burst mid-way:
- state=FETCH_CF.
- Task_Pointer, frames_left, Insn_Load_Counter, frames_issued = 0.
- Start, Init_R0_Vect, Init_R0 = 0.
- fence=NO, halted=0.
REQ-030 The first CF SHALL be evaluated on the first clk edge after reset deasserts.

Configuration
REQ-031 With macro TS_VGA_SYNC_EN defined:
- Ports vga_end (in, 1), vga_en (out, 1) and parameter FRAME_TICKS (default 833333) SHALL exist.
- vga_en SHALL pulse for 1 cycle when an internal tick counter reaches FRAME_TICKS-1 while all Ready=1.
- PARK SHALL exit only on a vga_end rising edge.
REQ-032 Without TS_VGA_SYNC_EN, those ports and the counter SHALL be absent and PARK SHALL exit on all Ready=1.

Structure
REQ-033 Package ts_pkg SHALL hold the fence encodings, the CF field offset functions of the parameters, and the state enum.
REQ-034 Sub-module ts_frame_decode (combinational CF field extraction) is natural; the FSM, counters and sync logic stay in the top module.

Verification
REQ-035 Verification SHALL cover the following directed scenarios, with default parameters:
- CF{IF_NUM=2, ACTIVE=0101, FENCE=NO} with all Ready -> two 4-cycle Start=0101 bursts, counter 0,1,2,3 each, frames_issued=2, TP=3.
- Same CF with Ready[0]=0 held -> no Start, TP=0, until Ready[0]=1, then burst on the next cycle.
- CF FENCE=REL, ACTIVE=0001, with Ready=1110 -> wait; Ready=1111 -> accept.
- CF{IF_NUM=1, STOP=1, STOP_ADDR=5} -> after the burst TP=5, fence=ACQ, next CF waits for all Ready; TP=15 then IF_NUM=0/STOP=0 wraps to 0.
- Reset asserted at beat 2 -> Start=0 in the same cycle, all outputs zero.
- With TS_VGA_SYNC_EN and FRAME_TICKS=8: STOP/IF_NUM=0 parks, halted=1, exit one cycle after a vga_end rising edge.
